// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle 32-bit signed/unsigned divider with pipeline stall handshake.
// Radix-2 restoring division, one quotient bit per cycle, MSB first.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [5:0]  stall,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic        div_rem,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        div_ready,
  output logic [31:0] div_result
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           op_signed_q, op_signed_d;
  logic           op_rem_q, op_rem_d;
  logic           neg_a_q, neg_a_d;
  logic           neg_b_q, neg_b_d;
  logic [W-1:0]   dvd_q, dvd_d;      // dividend magnitude, shifts out as quotient shifts in
  logic [W-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic [W:0]     prem_q, prem_d;    // partial remainder
  logic [W-1:0]   result_q, result_d;

  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     prem_shift, prem_sub, prem_nxt;
  logic           q_bit;
  logic [W-1:0]   quo_nxt, quo_fix, rem_fix;
  logic           unused_stall;

  assign unused_stall = ^{stall[5:3], stall[1:0]};

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    abs_a      = (div_signed && src_a[W-1]) ? W'(-src_a) : src_a;
    abs_b      = (div_signed && src_b[W-1]) ? W'(-src_b) : src_b;
    prem_shift = {prem_q[W-1:0], dvd_q[W-1]};
    prem_sub   = prem_shift - {1'b0, dvs_q};
    q_bit      = ~prem_sub[W];
    prem_nxt   = q_bit ? prem_sub : prem_shift;
    quo_nxt    = {dvd_q[W-2:0], q_bit};
    quo_fix    = (op_signed_q && (neg_a_q ^ neg_b_q)) ? W'(-quo_nxt) : quo_nxt;
    rem_fix    = (op_signed_q && neg_a_q) ? W'(-prem_nxt[W-1:0]) : prem_nxt[W-1:0];
  end

  // Next-state and datapath control; flush overrides everything except reset.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_signed_d = op_signed_q;
    op_rem_d    = op_rem_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    result_d    = '0;

    case (state_q)
      IDLE: begin
        if (div_req && !flush) begin
          op_signed_d = div_signed;
          op_rem_d    = div_rem;
          neg_a_d     = div_signed & src_a[W-1];
          neg_b_d     = div_signed & src_b[W-1];
          dvd_d       = abs_a;
          dvs_d       = abs_b;
          prem_d      = '0;
          count_d     = '0;
          if (src_b == '0) begin
            state_d  = DONE;
            result_d = div_rem ? src_a : '1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            state_d  = DONE;
            result_d = div_rem ? src_a : '0;
          end
`endif
          else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prem_d  = prem_nxt;
        dvd_d   = quo_nxt;
        count_d = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          state_d  = DONE;
          result_d = op_rem_q ? rem_fix : quo_fix;
        end
      end
      DONE: begin
        result_d = result_q;
        if (!stall[2]) begin
          state_d  = IDLE;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      count_d  = '0;
      result_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      op_signed_q <= 1'b0;
      op_rem_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_signed_q <= op_signed_d;
      op_rem_q    <= op_rem_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      result_q    <= result_d;
    end
  end

  // Stall request must respond within the request cycle, so it is decoded from current inputs.
  assign stallreq   = ~reset & ~flush & (((state_q == IDLE) & div_req) | (state_q == BUSY));
  assign div_ready  = (state_q == DONE);
  assign div_result = result_q;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on posedge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: flush  input  1  pipeline flush; aborts any divide.
REQ-004 SHALL have port: stall  input  6  pipeline stall vector; bit 2 = EX held.
REQ-005 SHALL have port: div_req  input  1  divide/modulo instruction present in EX.
REQ-006 SHALL have port: div_signed  input  1  1 = signed operands, 0 = unsigned.
REQ-007 SHALL have port: div_rem  input  1  1 = return remainder, 0 = return quotient.
REQ-008 SHALL have port: src_a  input  32  dividend.
REQ-009 SHALL have port: src_b  input  32  divisor.
REQ-010 SHALL have port: stallreq  output  1  EX stall request to pipeline control.
REQ-011 SHALL have port: div_ready  output  1  result valid.
REQ-012 SHALL have port: div_result  output  32  quotient or remainder per latched div_rem.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: div_req=1 and flush=0 -> latch div_signed, div_rem, operand signs, |src_a|, |src_b| (absolute value only when div_signed=1); go BUSY with count=0.
REQ-015 IDLE, div_req=1, src_b=0: go directly to DONE; quotient=32'hFFFF_FFFF, remainder=src_a.
REQ-016 BUSY: radix-2 restoring division, one quotient bit per cycle, MSB first; 33-bit partial remainder; count increments 0..31; count=31 -> DONE.
REQ-017 Latency: request seen in cycle N, BUSY cycles N+1..N+32, DONE (div_ready=1) in cycle N+33.
REQ-018 DONE: quotient negated when latched signs differ (signed only); remainder takes dividend sign (signed only); all arithmetic modulo 2^32.
REQ-019 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield quotient 32'h8000_0000, remainder 0.
REQ-020 stallreq SHALL equal (IDLE & div_req & ~flush) | BUSY; stallreq=0 in DONE.
REQ-021 DONE SHALL hold div_result and div_ready stable while stall[2]=1; go IDLE on first cycle with stall[2]=0 (instruction advances).
REQ-022 Operand changes on src_a/src_b/div_signed/div_rem after latching SHALL NOT affect the result.
REQ-023 flush=1 in any state SHALL force stallreq=0 that cycle and state IDLE next cycle; no result produced.
REQ-024 flush and div_req in same IDLE cycle: flush wins; no divide starts.
REQ-025 div_ready=0 and div_result=0 in IDLE and BUSY.

Reset
REQ-026 reset=1 SHALL set state IDLE, count 0, all latched operands 0, stallreq 0, div_ready 0, div_result 0 on the next edge.
REQ-027 reset mid-BUSY or mid-DONE SHALL abandon the operation with no residual output.
REQ-028 reset SHALL have priority over flush and div_req.

Configuration
REQ-029 Macro DIV_EARLY_OUT_EN defined: IDLE with |src_a| < |src_b| (unsigned compare of latched magnitudes, src_b nonzero) SHALL go directly to DONE with quotient 0, remainder src_a (latency 1 cycle).
REQ-030 DIV_EARLY_OUT_EN undefined: every nonzero-divisor divide SHALL take the full 32 BUSY cycles; divide-by-zero fast path (REQ-015) present in both builds.

Verification
REQ-031 Unsigned 100/7, div_rem=0, stall[2]=stallreq -> stallreq high 33 cycles, then div_ready=1, div_result=14.
REQ-032 Signed -7 (32'hFFFF_FFF9) mod 2, div_rem=1 -> div_result=32'hFFFF_FFFF; signed -7/2 -> 32'hFFFF_FFFD.
REQ-033 Signed 32'h8000_0000 / 32'hFFFF_FFFF -> quotient 32'h8000_0000; src_b=0, src_a=5 -> quotient 32'hFFFF_FFFF after 1 cycle, remainder 5.
REQ-034 flush asserted at BUSY count=10 -> stallreq 0 that cycle, IDLE next, div_ready never set; new 9/3 completes with 3.
REQ-035 DONE with stall[2] held high 4 extra cycles (MEM stall) -> div_result constant, div_ready=1 throughout, IDLE after stall[2] drops.
REQ-036 With DIV_EARLY_OUT_EN: 3/10 unsigned -> div_ready next cycle, quotient 0; without it: 33-cycle latency, quotient 0.
